// File: rtl/sseg_pkg.sv
// Shared constants, state encoding and nibble helper for the seven-segment scan controller.
package sseg_pkg;
   localparam int         DIGITS = 4;
   localparam logic [3:0] AN_OFF = 4'b1111;

   typedef enum logic {S_BLANK, S_ON} state_t;

   function automatic logic [3:0] nib_of(input logic [15:0] v, input logic [1:0] i);
      return v[{i, 2'b00} +: 4];
   endfunction
endpackage

// File: rtl/sseg_slot_timer.sv
// Per-slot cycle counter: marks the slot wrap, the end of the blanking gap and the frame end.
module sseg_slot_timer #(
   parameter int PRESCALE = 100000,
   parameter int BLANK    = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic last_digit,
   output logic slot_wrap,
   output logic on_start,
   output logic frame_end
);
   localparam int CW = $clog2(PRESCALE);
   localparam logic [CW-1:0] LAST  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] ON_AT = CW'((BLANK == 0) ? 0 : BLANK - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst)           cnt <= '0;
      else if (slot_wrap) cnt <= '0;
      else                cnt <= cnt + 1'b1;
   end

   assign slot_wrap = (cnt == LAST);
   // With no blanking gap there is no blank-to-on transition inside a slot.
   assign on_start  = (BLANK != 0) && (cnt == ON_AT);
   assign frame_end = slot_wrap && last_digit;
endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit scan scheduler: frame-synchronous shadow load, blanking gap, digit mask and
// leading-zero suppression feeding the downstream segment decoder.
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int PRESCALE = 100000,
   parameter int BLANK    = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic        value_valid,
   output logic        value_ready,
   input  logic [3:0]  digit_en,
   input  logic        lzs,
   output logic [1:0]  digit_sel,
   output logic [3:0]  digit_nib,
   output logic        digit_dp,
   output logic [3:0]  sseg_an,
   output logic        frame_tick
);
   logic        slot_wrap, on_start, frame_end, load, an_upd, zero_run;
   logic [1:0]  sel_nxt;
   logic [15:0] shadow, shadow_nxt;
   logic [3:0]  dp_sh, dp_nxt, sup, show;
   state_t      state, state_nxt;

   sseg_slot_timer #(.PRESCALE(PRESCALE), .BLANK(BLANK)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .last_digit (digit_sel == 2'd3),
      .slot_wrap  (slot_wrap),
      .on_start   (on_start),
      .frame_end  (frame_end)
   );

   assign value_ready = frame_end;
   assign frame_tick  = frame_end;
   assign load        = frame_end && value_valid;
   assign sel_nxt     = slot_wrap ? digit_sel + 2'd1 : digit_sel;
   assign shadow_nxt  = load ? value : shadow;
   assign dp_nxt      = load ? dp_in : dp_sh;

   always_comb begin
      state_nxt = state;
      case (state)
         S_BLANK: if (BLANK == 0 || on_start)  state_nxt = S_ON;
         S_ON:    if (BLANK != 0 && slot_wrap) state_nxt = S_BLANK;
         default: state_nxt = S_BLANK;
      endcase
   end

   // A digit is a leading zero when it and every more-significant nibble are zero.
   always_comb begin
      zero_run = 1'b1;
      sup      = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (nib_of(shadow_nxt, 2'(i)) == 4'h0);
         sup[i]   = lzs & zero_run & (i != 0);
      end
      show = digit_en & ~sup;
   end

   // Anodes only move on entry to the lit phase of a slot or when blanking begins.
   assign an_upd = (state_nxt == S_ON) && (state == S_BLANK || slot_wrap);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_BLANK;
         digit_sel <= 2'd0;
         shadow    <= 16'h0;
         dp_sh     <= 4'h0;
         digit_nib <= 4'h0;
         digit_dp  <= 1'b1;
         sseg_an   <= AN_OFF;
      end else begin
         state     <= state_nxt;
         digit_sel <= sel_nxt;
         shadow    <= shadow_nxt;
         dp_sh     <= dp_nxt;
         digit_nib <= nib_of(shadow_nxt, sel_nxt);
         digit_dp  <= ~dp_nxt[sel_nxt];
         if (an_upd)
            sseg_an <= show[sel_nxt] ? ~(4'b0001 << sel_nxt) : AN_OFF;
         else if (state_nxt == S_BLANK)
            sseg_an <= AN_OFF;
      end
   end
endmodule
